bank_arbiter: RTL and testbench
===============================

BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 Parameter NUM_BANKS, default 3, number of SDRAM frame banks; legal range 3..8.
REQ-002 Parameter ADDR_W, default 13, width of the captured frame-end address.
REQ-003 Parameter MODE, default 0; 0 = LATEST (reader always shows newest frame), 1 = FIFO (reader shows frames in write order).
REQ-004 Parameter BANK_W, derived as $clog2(NUM_BANKS), width of all bank indices; not overridden by users.
REQ-005 clk  input  1  single system clock (133 MHz SDRAM domain); all logic on its rising edge.
REQ-006 rst_133  input  1  reset, asynchronous assert, active-low.
REQ-007 en  input  1  arbitration enable; when low, no bank or queue state changes.
REQ-008 vga_rise  input  1  reader frame level, asynchronous; falling edge = reader frame end.
REQ-009 cam_rise  input  1  writer frame level, asynchronous; rising edge = writer frame end.
REQ-010 wr_addr_i  input  ADDR_W  writer's current SDRAM address, sampled on writer frame end.
REQ-011 vga_bank  output  BANK_W  bank currently owned by the reader.
REQ-012 cam_bank  output  BANK_W  bank currently owned by the writer.
REQ-013 rd_addr_o  output  ADDR_W  captured end address of the frame in vga_bank.
REQ-014 full_cnt  output  BANK_W+1  number of completed frames waiting for the reader.
REQ-015 drop_p  output  1  one-cycle pulse when a waiting frame is discarded to free a bank.

Function
REQ-016 vga_rise and cam_rise SHALL each pass through a two-flop synchroniser; events are rd_ev = ~s1 & s2 (vga) and wr_ev = s1 & ~s2 (cam); event-to-output latency is 3 clk cycles.
REQ-017 Every bank SHALL be in exactly one state: FREE, WRITING, FULL, READING; exactly one bank is WRITING and one READING at all times.
REQ-018 FULL banks SHALL be held in an ordered queue of depth NUM_BANKS-2 (head = oldest); full_cnt equals queue occupancy.
REQ-019 On wr_ev: the WRITING bank becomes FULL, is pushed at queue tail, and its end address is stored as wr_addr_i; the writer takes the lowest-index FREE bank.
REQ-020 On wr_ev with no FREE bank: the queue head is popped, becomes the new WRITING bank, and drop_p pulses for one cycle.
REQ-021 On rd_ev with full_cnt = 0: no change; the reader repeats its current bank.
REQ-022 On rd_ev, MODE = LATEST: the tail bank becomes READING, the old READING bank and all other queued banks become FREE, full_cnt becomes 0.
REQ-023 On rd_ev, MODE = FIFO: the head bank becomes READING, the old READING bank becomes FREE, full_cnt decrements by 1.
REQ-024 Simultaneous wr_ev and rd_ev: writer push applied first, then reader selection on the updated queue, then writer picks lowest-index FREE bank including the bank just released by the reader; no drop occurs in this case.
REQ-025 rd_addr_o SHALL update in the same cycle as vga_bank.
REQ-026 Events occurring while en is low SHALL be discarded, not deferred; synchronisers keep running.

Reset
REQ-027 On rst_133 low: vga_bank = 0 (READING), cam_bank = 1 (WRITING), banks 2..N-1 FREE, queue empty, full_cnt = 0, rd_addr_o = 0, all stored addresses 0, drop_p = 0, synchroniser flops 0.
REQ-028 Reset asserted mid-frame SHALL abandon all queued frames with no drop_p pulse.

Configuration
REQ-029 Macro BANK_ARB_DROP_CNT_EN defined: extra output drop_cnt (16 bits, saturating at 16'hFFFF, reset 0) counts drop_p pulses; undefined: port and counter absent, drop_p unaffected.

Structure
REQ-030 Shared package bank_arb_pkg holds bank state enum (FREE/WRITING/FULL/READING), MODE constants LATEST/FIFO, and default NUM_BANKS/ADDR_W.
REQ-031 Sub-module bank_arb_edge_sync (two-flop synchroniser plus edge detector, polarity parameter) instantiated twice.

Verification
REQ-032 Reset, NUM_BANKS=3 -> vga_bank=0, cam_bank=1, full_cnt=0, drop_p=0.
REQ-033 N=3, LATEST, one cam rise with wr_addr_i=13'h0A5, then vga fall -> cam_bank=2, full_cnt=1; then vga_bank=1, rd_addr_o=13'h0A5, full_cnt=0.
REQ-034 N=4, FIFO, three cam rises, no vga -> queue banks 1,2 then drop_p on third with cam_bank=1, full_cnt=2; following vga fall gives vga_bank=2.
REQ-035 N=3, vga fall and cam rise in same cycle from reset -> vga_bank=1, cam_bank=0, full_cnt=0, no drop_p.
REQ-036 en=0 during cam rise and vga fall -> all outputs unchanged; rst_133 pulsed with full_cnt=1 -> reset values, no drop_p.

Source files
------------

// File: rtl/bank_arb_pkg.sv
// rtl/bank_arb_pkg.sv - shared types and constants for the frame bank arbiter
// Contents:
//   bank_state_e  - per-bank ownership state (FREE/WRITING/FULL/READING)
//   edge_pol_e    - edge polarity selector for bank_arb_edge_sync
//   LATEST, FIFO  - MODE values for bank_arbiter
//   DEF_NUM_BANKS, DEF_ADDR_W - default parameter values
package bank_arb_pkg;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      WRITING = 2'd1,
      FULL    = 2'd2,
      READING = 2'd3
   } bank_state_e;

   typedef enum logic {
      EDGE_FALL = 1'b0,
      EDGE_RISE = 1'b1
   } edge_pol_e;

   localparam int LATEST = 0;
   localparam int FIFO   = 1;

   localparam int DEF_NUM_BANKS = 3;
   localparam int DEF_ADDR_W    = 13;

endpackage

// File: rtl/bank_arb_edge_sync.sv
// rtl/bank_arb_edge_sync.sv - two-flop synchroniser with single-cycle edge detect
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset, clears all flops
//   i_level  in   asynchronous level input
//   o_event  out  one-cycle pulse on the selected edge of the synchronised level
// Parameter POL selects rising (EDGE_RISE) or falling (EDGE_FALL) detection.
module bank_arb_edge_sync
   import bank_arb_pkg::*;
#(
   parameter edge_pol_e POL = EDGE_RISE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_event
);

   // r_meta/r_s1 form the synchroniser; r_s2 is the one-cycle history of
   // the synchronised level used for edge detection.
   logic r_meta;
   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
      end else begin
         r_meta <= i_level;
         r_s1   <= r_meta;
         r_s2   <= r_s1;
      end
   end

   assign o_event = (POL == EDGE_RISE) ? (r_s1 & ~r_s2) : (~r_s1 & r_s2);

endmodule

// File: rtl/bank_arbiter.sv
// rtl/bank_arbiter.sv - SDRAM frame bank arbiter between a camera writer and a VGA reader
// Ports:
//   clk        in   system clock
//   rst_133    in   asynchronous active-low reset
//   en         in   arbitration enable; events seen while low are discarded
//   vga_rise   in   reader frame level (async); falling edge ends a reader frame
//   cam_rise   in   writer frame level (async); rising edge ends a writer frame
//   wr_addr_i  in   writer's current SDRAM address, captured at writer frame end
//   vga_bank   out  bank owned by the reader
//   cam_bank   out  bank owned by the writer
//   rd_addr_o  out  captured end address of the frame in vga_bank
//   full_cnt   out  completed frames waiting for the reader
//   drop_cnt   out  saturating count of drop_p pulses (BANK_ARB_DROP_CNT_EN only)
//   drop_p     out  one-cycle pulse when a waiting frame is discarded
// Optional feature macro: BANK_ARB_DROP_CNT_EN
module bank_arbiter
   import bank_arb_pkg::*;
#(
   parameter int NUM_BANKS = DEF_NUM_BANKS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MODE      = LATEST,
   parameter int BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic              clk,
   input  logic              rst_133,
   input  logic              en,
   input  logic              vga_rise,
   input  logic              cam_rise,
   input  logic [ADDR_W-1:0] wr_addr_i,
   output logic [BANK_W-1:0] vga_bank,
   output logic [BANK_W-1:0] cam_bank,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic [BANK_W:0]   full_cnt,
`ifdef BANK_ARB_DROP_CNT_EN
   output logic [15:0]       drop_cnt,
`endif
   output logic              drop_p
);

   localparam int QDEPTH = NUM_BANKS - 2;  // stored queue depth
   localparam int WDEPTH = NUM_BANKS - 1;  // working depth: one transient extra push
   localparam int CNT_W  = BANK_W + 1;

   logic w_wr_ev;
   logic w_rd_ev;
   logic w_wr;
   logic w_rd;

   bank_arb_edge_sync #(.POL(EDGE_RISE)) u_cam_sync (
      .clk     (clk),
      .rst_n   (rst_133),
      .i_level (cam_rise),
      .o_event (w_wr_ev)
   );

   bank_arb_edge_sync #(.POL(EDGE_FALL)) u_vga_sync (
      .clk     (clk),
      .rst_n   (rst_133),
      .i_level (vga_rise),
      .o_event (w_rd_ev)
   );

   assign w_wr = en & w_wr_ev;
   assign w_rd = en & w_rd_ev;

   bank_state_e       r_state [NUM_BANKS];
   logic [ADDR_W-1:0] r_addr  [NUM_BANKS];
   logic [BANK_W-1:0] r_q     [QDEPTH];
   logic [CNT_W-1:0]  r_qcnt;
   logic [BANK_W-1:0] r_vga;
   logic [BANK_W-1:0] r_cam;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_drop;

   bank_state_e       w_state [NUM_BANKS];
   logic [ADDR_W-1:0] w_addr  [NUM_BANKS];
   logic [BANK_W-1:0] w_q     [WDEPTH];
   int                w_cnt;
   logic [BANK_W-1:0] w_vga;
   logic [BANK_W-1:0] w_cam;
   logic [BANK_W-1:0] w_sel;
   logic [BANK_W-1:0] w_free;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_drop;
   logic              w_found;

   // Next-state: writer push, then reader selection on the updated queue,
   // then writer picks a new bank (which may be the one the reader just left).
   always_comb begin
      w_state   = r_state;
      w_addr    = r_addr;
      for (int i = 0; i < WDEPTH; i++) w_q[i] = '0;
      for (int i = 0; i < QDEPTH; i++) w_q[i] = r_q[i];
      w_cnt     = int'(r_qcnt);
      w_vga     = r_vga;
      w_cam     = r_cam;
      w_sel     = r_vga;
      w_free    = '0;
      w_rd_addr = r_rd_addr;
      w_drop    = 1'b0;
      w_found   = 1'b0;

      if (w_wr) begin
         w_state[r_cam] = FULL;
         w_addr[r_cam]  = wr_addr_i;
         for (int i = 0; i < WDEPTH; i++) begin
            if (i == w_cnt) w_q[i] = r_cam;
         end
         w_cnt = w_cnt + 1;
      end

      if (w_rd && (w_cnt != 0)) begin
         w_state[r_vga] = FREE;
         if (MODE == LATEST) begin
            // Newest frame wins; everything older in the queue is released.
            for (int i = 0; i < WDEPTH; i++) begin
               if (i == w_cnt - 1)  w_sel = w_q[i];
               else if (i < w_cnt)  w_state[w_q[i]] = FREE;
            end
            w_cnt = 0;
         end else begin
            w_sel = w_q[0];
            for (int i = 0; i < WDEPTH - 1; i++) w_q[i] = w_q[i+1];
            w_cnt = w_cnt - 1;
         end
         w_state[w_sel] = READING;
         w_vga          = w_sel;
         w_rd_addr      = w_addr[w_sel];
      end

      if (w_wr) begin
         // Descending scan so the lowest FREE index is the last one kept.
         for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (w_state[i] == FREE) begin
               w_found = 1'b1;
               w_free  = BANK_W'(i);
            end
         end
         if (w_found) begin
            w_cam          = w_free;
            w_state[w_free] = WRITING;
         end else begin
            // No free bank: recycle the oldest waiting frame for the writer.
            w_cam            = w_q[0];
            w_state[w_q[0]]  = WRITING;
            for (int i = 0; i < WDEPTH - 1; i++) w_q[i] = w_q[i+1];
            w_cnt  = w_cnt - 1;
            w_drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_133) begin
      if (!rst_133) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_state[i] <= (i == 0) ? READING : ((i == 1) ? WRITING : FREE);
            r_addr[i]  <= '0;
         end
         for (int i = 0; i < QDEPTH; i++) r_q[i] <= '0;
         r_qcnt    <= '0;
         r_vga     <= BANK_W'(0);
         r_cam     <= BANK_W'(1);
         r_rd_addr <= '0;
         r_drop    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_addr    <= w_addr;
         for (int i = 0; i < QDEPTH; i++) r_q[i] <= w_q[i];
         r_qcnt    <= CNT_W'(w_cnt);
         r_vga     <= w_vga;
         r_cam     <= w_cam;
         r_rd_addr <= w_rd_addr;
         r_drop    <= w_drop;
      end
   end

`ifdef BANK_ARB_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_133) begin
      if (!rst_133) begin
         r_drop_cnt <= '0;
      end else if (r_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign vga_bank  = r_vga;
   assign cam_bank  = r_cam;
   assign rd_addr_o = r_rd_addr;
   assign full_cnt  = r_qcnt;
   assign drop_p    = r_drop;

endmodule

// File: tb/tb_bank_arbiter.sv
// tb/tb_bank_arbiter.sv - self-checking bench for bank_arbiter (N=3 LATEST, N=4 FIFO, N=5 LATEST)
module tb_bank_arbiter;

   logic        clk = 1'b0;
   logic        rst_133 = 1'b0;
   logic        en = 1'b1;
   logic        vga_rise = 1'b1;
   logic        cam_rise = 1'b0;
   logic [12:0] wr_addr = '0;

   logic [1:0]  d0_vga, d0_cam;
   logic [2:0]  d0_cnt;
   logic [12:0] d0_rd;
   logic        d0_drop;
   logic [1:0]  d1_vga, d1_cam;
   logic [2:0]  d1_cnt;
   logic [12:0] d1_rd;
   logic        d1_drop;
   logic [2:0]  d2_vga, d2_cam;
   logic [3:0]  d2_cnt;
   logic [12:0] d2_rd;
   logic        d2_drop;
`ifdef BANK_ARB_DROP_CNT_EN
   logic [15:0] d0_dcnt, d1_dcnt, d2_dcnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bank_arbiter #(.NUM_BANKS(3), .ADDR_W(13), .MODE(0)) u_d0 (
      .clk(clk), .rst_133(rst_133), .en(en), .vga_rise(vga_rise), .cam_rise(cam_rise),
      .wr_addr_i(wr_addr), .vga_bank(d0_vga), .cam_bank(d0_cam), .rd_addr_o(d0_rd),
      .full_cnt(d0_cnt),
`ifdef BANK_ARB_DROP_CNT_EN
      .drop_cnt(d0_dcnt),
`endif
      .drop_p(d0_drop));

   bank_arbiter #(.NUM_BANKS(4), .ADDR_W(13), .MODE(1)) u_d1 (
      .clk(clk), .rst_133(rst_133), .en(en), .vga_rise(vga_rise), .cam_rise(cam_rise),
      .wr_addr_i(wr_addr), .vga_bank(d1_vga), .cam_bank(d1_cam), .rd_addr_o(d1_rd),
      .full_cnt(d1_cnt),
`ifdef BANK_ARB_DROP_CNT_EN
      .drop_cnt(d1_dcnt),
`endif
      .drop_p(d1_drop));

   bank_arbiter #(.NUM_BANKS(5), .ADDR_W(13), .MODE(0)) u_d2 (
      .clk(clk), .rst_133(rst_133), .en(en), .vga_rise(vga_rise), .cam_rise(cam_rise),
      .wr_addr_i(wr_addr), .vga_bank(d2_vga), .cam_bank(d2_cam), .rd_addr_o(d2_rd),
      .full_cnt(d2_cnt),
`ifdef BANK_ARB_DROP_CNT_EN
      .drop_cnt(d2_dcnt),
`endif
      .drop_p(d2_drop));

   // Observed outputs packed as {vga, cam, cnt, rd_addr} in nibble-aligned fields.
   function automatic logic [31:0] got(input int k);
      case (k)
         0:       got = {4'h0, 2'b0, d0_vga, 2'b0, d0_cam, 1'b0, d0_cnt, 3'b0, d0_rd};
         1:       got = {4'h0, 2'b0, d1_vga, 2'b0, d1_cam, 1'b0, d1_cnt, 3'b0, d1_rd};
         default: got = {4'h0, 1'b0, d2_vga, 1'b0, d2_cam, d2_cnt, 3'b0, d2_rd};
      endcase
   endfunction

   function automatic logic got_drop(input int k);
      case (k)
         0:       got_drop = d0_drop;
         1:       got_drop = d1_drop;
         default: got_drop = d2_drop;
      endcase
   endfunction

   function automatic logic [31:0] exp_pack(input int v, input int c, input int n, input int r);
      return (v << 24) | (c << 20) | (n << 16) | r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_133 = 1'b0; cam_rise = 1'b0; vga_rise = 1'b1; en = 1'b1; wr_addr = '0;
      tick(2);
      rst_133 = 1'b1;
      tick(2);
   endtask

   // ---------------- reference model: banks as a reader, a writer and an ordered list
   function automatic int nb(input int k);
      return (k == 0) ? 3 : ((k == 1) ? 4 : 5);
   endfunction
   function automatic bit is_fifo(input int k);
      return (k == 1);
   endfunction

   int   m_vga [3];
   int   m_cam [3];
   int   m_cnt [3];
   int   m_rd  [3];
   bit   m_drop[3];
   int   m_q   [3][8];
   int   m_addr[3][8];
   logic [2:0] ch = 3'b0;
   logic [2:0] vh = 3'b0;
   bit   m_wr, m_rdev;

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         m_vga[k] = 0; m_cam[k] = 1; m_cnt[k] = 0; m_rd[k] = 0; m_drop[k] = 0;
         for (int b = 0; b < 8; b++) begin m_q[k][b] = 0; m_addr[k][b] = 0; end
      end
   endtask

   task automatic m_pop(input int k);
      for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
      m_cnt[k] = m_cnt[k] - 1;
   endtask

   task automatic m_step(input int k, input bit wr, input bit rd, input int addr);
      int  sel;
      int  f;
      bit  busy;
      m_drop[k] = 0;
      if (wr) begin
         m_addr[k][m_cam[k]] = addr;
         m_q[k][m_cnt[k]] = m_cam[k];
         m_cnt[k] = m_cnt[k] + 1;
      end
      if (rd && m_cnt[k] > 0) begin
         if (is_fifo(k)) begin
            sel = m_q[k][0];
            m_pop(k);
         end else begin
            sel = m_q[k][m_cnt[k]-1];
            m_cnt[k] = 0;
         end
         m_vga[k] = sel;
         m_rd[k]  = m_addr[k][sel];
      end
      if (wr) begin
         f = -1;
         for (int b = nb(k) - 1; b >= 0; b--) begin
            busy = (b == m_vga[k]);
            for (int i = 0; i < m_cnt[k]; i++) if (m_q[k][i] == b) busy = 1;
            if (!busy) f = b;
         end
         if (f >= 0) m_cam[k] = f;
         else begin
            m_cam[k] = m_q[k][0];
            m_pop(k);
            m_drop[k] = 1;
         end
      end
   endtask

   // A level change seen at edge E acts at edge E+2 (three-cycle latency).
   always @(posedge clk or negedge rst_133) begin
      if (!rst_133) begin
         m_reset();
         ch = 3'b0;
         vh = 3'b0;
      end else begin
         m_wr   = en && ch[1] && !ch[2];
         m_rdev = en && !vh[1] && vh[2];
         for (int k = 0; k < 3; k++) m_step(k, m_wr, m_rdev, int'(wr_addr));
         ch = {ch[1:0], cam_rise};
         vh = {vh[1:0], vga_rise};
      end
   end

   // ---------------- directed vectors: inputs held 4 cycles, then all DUTs compared
   typedef struct {
      logic        cam;
      logic        vga;
      logic        en;
      logic [12:0] addr;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 13'h000, exp_pack(0,1,0,0),       exp_pack(0,1,0,0),       exp_pack(0,1,0,0)};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 13'h0A5, exp_pack(0,2,1,0),       exp_pack(0,2,1,0),       exp_pack(0,2,1,0)};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 13'h0A5, exp_pack(1,2,0,'h0A5),   exp_pack(1,2,0,'h0A5),   exp_pack(1,2,0,'h0A5)};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 13'h111, exp_pack(1,2,0,'h0A5),   exp_pack(1,2,0,'h0A5),   exp_pack(1,2,0,'h0A5)};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 13'h0B2, exp_pack(1,0,1,'h0A5),   exp_pack(1,0,1,'h0A5),   exp_pack(1,0,1,'h0A5)};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 13'h0B2, exp_pack(1,0,1,'h0A5),   exp_pack(1,0,1,'h0A5),   exp_pack(1,0,1,'h0A5)};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 13'h0C3, exp_pack(1,2,1,'h0A5),   exp_pack(1,3,2,'h0A5),   exp_pack(1,3,2,'h0A5)};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 13'h0C3, exp_pack(0,2,0,'h0C3),   exp_pack(2,3,1,'h0B2),   exp_pack(0,3,0,'h0C3)};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 13'h0C3, exp_pack(0,2,0,'h0C3),   exp_pack(2,3,1,'h0B2),   exp_pack(0,3,0,'h0C3)};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 13'h1FF, exp_pack(0,2,0,'h0C3),   exp_pack(2,3,1,'h0B2),   exp_pack(0,3,0,'h0C3)};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 13'h1FF, exp_pack(0,2,0,'h0C3),   exp_pack(2,3,1,'h0B2),   exp_pack(0,3,0,'h0C3)};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 13'h1FF, exp_pack(0,2,0,'h0C3),   exp_pack(2,3,1,'h0B2),   exp_pack(0,3,0,'h0C3)};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 13'h0D4, exp_pack(2,0,0,'h0D4),   exp_pack(0,1,1,'h0C3),   exp_pack(3,0,0,'h0D4)};

      // Reset state
      rst_133 = 1'b0; cam_rise = 1'b0; vga_rise = 1'b1; en = 1'b1; wr_addr = '0;
      tick(3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_d%0d", k), got(k), exp_pack(0,1,0,0));
         check($sformatf("reset_drop_d%0d", k), {31'b0, got_drop(k)}, 32'd0);
      end
      rst_133 = 1'b1;
      tick(2);

      for (int i = 0; i < 13; i++) begin
         cam_rise = vecs[i].cam; vga_rise = vecs[i].vga; en = vecs[i].en; wr_addr = vecs[i].addr;
         tick(4);
         check($sformatf("vec%0d_d0", i), got(0), vecs[i].exp0);
         check($sformatf("vec%0d_d1", i), got(1), vecs[i].exp1);
         check($sformatf("vec%0d_d2", i), got(2), vecs[i].exp2);
      end

      // Event-to-output latency is exactly three cycles
      do_reset();
      cam_rise = 1'b1;
      tick(2);
      check("latency_before", {30'b0, d0_cam}, 32'd1);
      tick(1);
      check("latency_at3", {30'b0, d0_cam}, 32'd2);

      // N=4 FIFO: third frame with no reader drops the oldest waiting frame
      do_reset();
      cam_rise = 1'b1; tick(3);
      check("fifo_e1", got(1), exp_pack(0,2,1,0));
      cam_rise = 1'b0; tick(2);
      cam_rise = 1'b1; tick(3);
      check("fifo_e2", got(1), exp_pack(0,3,2,0));
      check("n3_drop_pulse", {31'b0, d0_drop}, 32'd1);
      tick(1);
      check("n3_drop_end", {31'b0, d0_drop}, 32'd0);
      cam_rise = 1'b0; tick(2);
      cam_rise = 1'b1; tick(3);
      check("fifo_e3", got(1), exp_pack(0,1,2,0));
      check("fifo_drop_pulse", {31'b0, d1_drop}, 32'd1);
      tick(1);
      check("fifo_drop_end", {31'b0, d1_drop}, 32'd0);
      vga_rise = 1'b0; tick(3);
      check("fifo_read_head", {30'b0, d1_vga}, 32'd2);
`ifdef BANK_ARB_DROP_CNT_EN
      check("fifo_drop_cnt", {16'b0, d1_dcnt}, 32'd1);
`endif

      // Simultaneous reader and writer events from reset
      do_reset();
      wr_addr = 13'h0E7; cam_rise = 1'b1; vga_rise = 1'b0;
      tick(3);
      check("simul_d0", got(0), exp_pack(1,0,0,'h0E7));
      for (int k = 0; k < 3; k++)
         check($sformatf("simul_drop_d%0d", k), {31'b0, got_drop(k)}, 32'd0);

      // Reset with a frame waiting abandons it silently
      do_reset();
      wr_addr = 13'h0F1; cam_rise = 1'b1;
      tick(3);
      check("midrst_pre", {29'b0, d0_cnt}, 32'd1);
      rst_133 = 1'b0;
      #1;
      check("midrst_vals", got(0), exp_pack(0,1,0,0));
      check("midrst_drop", {31'b0, d0_drop}, 32'd0);
      cam_rise = 1'b0;
      tick(2);
      rst_133 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick(1);
         check($sformatf("postrst_%0d", c), {28'b0, d0_cnt, d0_drop}, 32'd0);
      end

      // Randomised run against the reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("rand_c%0d_d%0d", c, k), got(k),
                  exp_pack(m_vga[k], m_cam[k], m_cnt[k], m_rd[k]));
            check($sformatf("rand_drop_c%0d_d%0d", c, k), {31'b0, got_drop(k)},
                  {31'b0, m_drop[k]});
         end
         if (n_fail > 40) break;
         rst_133 = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 3) == 0) cam_rise = ~cam_rise;
         if ($urandom_range(0, 3) == 0) vga_rise = ~vga_rise;
         en = ($urandom_range(0, 9) != 0);
         wr_addr = 13'($urandom);
         tick(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
